// File: rtl/cache_ram_pkg.sv
// Shared types for the cache data-RAM write controller and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_ram_pkg;

    // Controller phase: sweeping the array, or serving requesters.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Requester identity; the value doubles as the bit index in req/gnt.
    typedef enum logic {
        GNT_FILL  = 1'b0,
        GNT_STORE = 1'b1
    } grant_t;

    // After reset the store side counts as last served, so fill wins the first tie.
    localparam grant_t LAST_GRANT_RST = GNT_STORE;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: one-hot grant plus the next last-grant value.
// Latency: purely combinational, grant in the same cycle as the request.
// Backpressure: a requester not granted simply sees no grant and must hold its request.
module rr_arb2
    import cache_ram_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt,
    output logic       next_grant
);

    // Fill wins if alone or if store was served last; otherwise store wins if requesting.
    always_comb begin
        gnt        = 2'b00;
        next_grant = last_grant;
        if (req[GNT_FILL] && (!req[GNT_STORE] || (last_grant == GNT_STORE))) begin
            gnt[GNT_FILL] = 1'b1;
            next_grant    = GNT_FILL;
        end else if (req[GNT_STORE]) begin
            gnt[GNT_STORE] = 1'b1;
            next_grant     = GNT_STORE;
        end
    end

endmodule

// File: rtl/cache_ram_ctrl.sv
// Write-port controller for the cache data RAM: clear sweep, fill/store round-robin, read pass-through.
// Latency: zero-cycle write acceptance; read data combinational (write visible on ram_q next cycle).
// Backpressure: readys drop during a clear sweep and for the arbitration loser. Optional: CACHE_RAM_FWD_EN.
module cache_ram_ctrl
    import cache_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 48,
    parameter int                    ADDR_WIDTH  = 11,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  flush_req,
    output logic                  busy,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  store_valid,
    output logic                  store_ready,
    input  logic [ADDR_WIDTH-1:0] store_addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_wraddress,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_rdaddress,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt;
    logic [ADDR_WIDTH-1:0]   sweep_cnt_nxt;
    grant_t                  last_grant;
    grant_t                  last_grant_nxt;
    logic [1:0]              gnt;
    logic                    arb_next;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    // Requests only reach the arbiter in RUN, so nothing is granted mid-sweep.
    rr_arb2 u_arb (
        .req        ({store_valid & (state == RUN), fill_valid & (state == RUN)}),
        .last_grant (last_grant),
        .gnt        (gnt),
        .next_grant (arb_next)
    );

    // State, sweep counter and round-robin history.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            sweep_cnt  <= '0;
            last_grant <= LAST_GRANT_RST;
        end else begin
            state      <= state_nxt;
            sweep_cnt  <= sweep_cnt_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Remember the last driven write address/data so the RAM bus stays quiet when idle.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else if (ram_wren) begin
            wr_addr_q <= ram_wraddress;
            wr_data_q <= ram_data;
        end
    end

    // Next-state logic and write-port mux; rst_n gates wren so it drops the instant reset asserts.
    always_comb begin
        state_nxt      = state;
        sweep_cnt_nxt  = sweep_cnt;
        last_grant_nxt = last_grant;
        busy           = 1'b1;
        fill_ready     = 1'b0;
        store_ready    = 1'b0;
        ram_wren       = 1'b0;
        ram_wraddress  = wr_addr_q;
        ram_data       = wr_data_q;
        case (state)
            CLEAR: begin
                ram_wren      = rst_n;
                ram_wraddress = sweep_cnt;
                ram_data      = CLEAR_VALUE;
                sweep_cnt_nxt = sweep_cnt + 1'b1;
                if (sweep_cnt == {ADDR_WIDTH{1'b1}}) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy          = 1'b0;
                sweep_cnt_nxt = '0;
                fill_ready    = gnt[GNT_FILL];
                store_ready   = gnt[GNT_STORE];
                ram_wren      = |gnt;
                if (gnt[GNT_FILL]) begin
                    ram_wraddress = fill_addr;
                    ram_data      = fill_data;
                end else if (gnt[GNT_STORE]) begin
                    ram_wraddress = store_addr;
                    ram_data      = store_data;
                end
                if (|gnt) begin
                    last_grant_nxt = grant_t'(arb_next);
                end
                // A write granted alongside the flush still lands this edge.
                if (flush_req) begin
                    state_nxt = CLEAR;
                end
            end
            default: ;
        endcase
    end

    assign ram_rdaddress = rd_addr;

    // Read path: optionally bypass the RAM when reading the word being written this cycle.
`ifdef CACHE_RAM_FWD_EN
    assign rd_data = (ram_wren && (ram_wraddress == rd_addr)) ? ram_data : ram_q;
`else
    assign rd_data = ram_q;
`endif

endmodule

// File: tb/tb_cache_ram_ctrl.sv
// Bench for cache_ram_ctrl with an attached asynchronous-read RAM model.
// Covers reset sweep, arbitration table, forwarding, flush, reset mid-sweep, random traffic.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_cache_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef CACHE_RAM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          rst_n;
    logic          flush_req;
    logic          busy;
    logic          fill_valid, fill_ready;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          store_valid, store_ready;
    logic [AW-1:0] store_addr;
    logic [DW-1:0] store_data;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          ram_wren;
    logic [AW-1:0] ram_wraddress;
    logic [DW-1:0] ram_data;
    logic [AW-1:0] ram_rdaddress;
    logic [DW-1:0] ram_q;

    always #5 clock = ~clock;

    cache_ram_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .CLEAR_VALUE (8'h00)
    ) dut (
        .clock         (clock),
        .rst_n         (rst_n),
        .flush_req     (flush_req),
        .busy          (busy),
        .fill_valid    (fill_valid),
        .fill_ready    (fill_ready),
        .fill_addr     (fill_addr),
        .fill_data     (fill_data),
        .store_valid   (store_valid),
        .store_ready   (store_ready),
        .store_addr    (store_addr),
        .store_data    (store_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .ram_wren      (ram_wren),
        .ram_wraddress (ram_wraddress),
        .ram_data      (ram_data),
        .ram_rdaddress (ram_rdaddress),
        .ram_q         (ram_q)
    );

    // Simple dual-port RAM, synchronous write, asynchronous read.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) if (ram_wren) ram[ram_wraddress] <= ram_data;
    assign ram_q = ram[ram_rdaddress];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs 16 sweep cycles starting from the current cycle; pulses flush mid-sweep (must be ignored).
    task automatic sweep_check(input string tag);
        for (int i = 0; i < 16; i++) begin
            flush_req = (i == 5);
            @(negedge clock);
            check({tag, "_busy"},   busy, 1);
            check({tag, "_wren"},   ram_wren, 1);
            check({tag, "_waddr"},  ram_wraddress, i);
            check({tag, "_wdata"},  ram_data, 0);
            check({tag, "_frdy"},   fill_ready, 0);
            check({tag, "_srdy"},   store_ready, 0);
            @(posedge clock); #1;
        end
        flush_req = 1'b0;
    endtask

    typedef struct {
        logic          fv;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
        logic          sv;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          efr;
        logic          esr;
        logic          ewr;
        logic [AW-1:0] ewa;
        logic [DW-1:0] ewd;
    } vec_t;

    vec_t vt [11];
    logic [AW-1:0] rb_addr [4];
    logic [DW-1:0] rb_data [4];

    // Random-phase reference state
    logic [DW-1:0] mem_m [16];
    int            sweep_left;
    bit            pref_fill;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;

    initial begin
        int            n;
        logic          e_busy, e_fr, e_sr, e_wr, take_f, take_s;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd, e_rd;

        //        fv fa    fd     sv sa    sd     efr esr ewr ewa   ewd
        vt[0]  = '{1, 4'd3, 8'hA5, 1, 4'd7, 8'h5A, 1,  0,  1, 4'd3, 8'hA5};
        vt[1]  = '{0, 4'd3, 8'hA5, 1, 4'd7, 8'h5A, 0,  1,  1, 4'd7, 8'h5A};
        vt[2]  = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0,  0,  0, 4'd7, 8'h5A};
        vt[3]  = '{1, 4'd1, 8'h10, 1, 4'd2, 8'h20, 1,  0,  1, 4'd1, 8'h10};
        vt[4]  = '{1, 4'd1, 8'h11, 1, 4'd2, 8'h20, 0,  1,  1, 4'd2, 8'h20};
        vt[5]  = '{1, 4'd1, 8'h11, 1, 4'd2, 8'h21, 1,  0,  1, 4'd1, 8'h11};
        vt[6]  = '{1, 4'd1, 8'h12, 1, 4'd2, 8'h21, 0,  1,  1, 4'd2, 8'h21};
        vt[7]  = '{1, 4'd1, 8'h12, 1, 4'd2, 8'h22, 1,  0,  1, 4'd1, 8'h12};
        vt[8]  = '{1, 4'd1, 8'h13, 1, 4'd2, 8'h22, 0,  1,  1, 4'd2, 8'h22};
        vt[9]  = '{1, 4'd1, 8'h13, 0, 4'd0, 8'h00, 1,  0,  1, 4'd1, 8'h13};
        vt[10] = '{0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0,  0,  0, 4'd1, 8'h13};
        rb_addr = '{4'd3, 4'd7, 4'd1, 4'd2};
        rb_data = '{8'hA5, 8'h5A, 8'h13, 8'h22};

        rst_n = 1'b0; flush_req = 1'b0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
        store_valid = 1'b0; store_addr = '0; store_data = '0;
        rd_addr = '0;

        // Reset state
        #2;
        check("rst_busy", busy, 1);
        check("rst_wren", ram_wren, 0);
        check("rst_frdy", fill_ready, 0);
        check("rst_srdy", store_ready, 0);
        @(posedge clock); #1;
        check("rst_wren_held", ram_wren, 0);
        rst_n = 1'b1;

        // Power-on sweep
        sweep_check("init");
        @(negedge clock);
        check("init_done_busy", busy, 0);
        check("init_done_wren", ram_wren, 0);
        for (int k = 0; k < 16; k++) begin
            rd_addr = AW'(k);
            #0.1;
            check("init_clear_rd", rd_data, 0);
        end
        @(posedge clock); #1;

        // Arbitration table
        for (int i = 0; i < 11; i++) begin
            fill_valid = vt[i].fv;  fill_addr = vt[i].fa;  fill_data = vt[i].fd;
            store_valid = vt[i].sv; store_addr = vt[i].sa; store_data = vt[i].sd;
            @(negedge clock);
            check($sformatf("tbl%0d_frdy", i),  fill_ready, vt[i].efr);
            check($sformatf("tbl%0d_srdy", i),  store_ready, vt[i].esr);
            check($sformatf("tbl%0d_wren", i),  ram_wren, vt[i].ewr);
            check($sformatf("tbl%0d_waddr", i), ram_wraddress, vt[i].ewa);
            check($sformatf("tbl%0d_wdata", i), ram_data, vt[i].ewd);
            @(posedge clock); #1;
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr = rb_addr[i];
            #1;
            check($sformatf("tbl_rd%0d", i), rd_data, rb_data[i]);
        end
        @(posedge clock); #1;

        // Read-after-write in the same cycle
        store_valid = 1'b1; store_addr = 4'd5; store_data = 8'h11;
        @(posedge clock); #1;
        store_data = 8'h3C; rd_addr = 4'd5;
        @(negedge clock);
        check("fwd_srdy", store_ready, 1);
        check("fwd_same_cycle", rd_data, FWD ? 8'h3C : 8'h11);
        @(posedge clock); #1;
        store_valid = 1'b0;
        @(negedge clock);
        check("fwd_next_cycle", rd_data, 8'h3C);
        @(posedge clock); #1;

        // Flush together with a granted fill
        fill_valid = 1'b1; fill_addr = 4'd2; fill_data = 8'hFF; flush_req = 1'b1;
        @(negedge clock);
        check("flush_frdy", fill_ready, 1);
        check("flush_wren", ram_wren, 1);
        check("flush_waddr", ram_wraddress, 2);
        check("flush_wdata", ram_data, 8'hFF);
        check("flush_busy0", busy, 0);
        @(posedge clock); #1;
        fill_valid = 1'b0; flush_req = 1'b0;
        store_valid = 1'b1; store_addr = 4'd4; store_data = 8'h77; rd_addr = 4'd2;
        #0.5;
        check("flush_fill_landed", rd_data, 8'hFF);
        sweep_check("flush");
        @(negedge clock);
        check("flush_done_busy", busy, 0);
        check("flush_done_srdy", store_ready, 1);
        check("flush_done_waddr", ram_wraddress, 4);
        @(posedge clock); #1;
        store_valid = 1'b0;
        rd_addr = 4'd2; #1;
        check("flush_entry2", rd_data, 8'h00);
        rd_addr = 4'd4; #1;
        check("flush_entry4", rd_data, 8'h77);
        @(posedge clock); #1;

        // Reset in the middle of a sweep
        flush_req = 1'b1;
        @(posedge clock); #1;
        flush_req = 1'b0;
        n = 0;
        @(negedge clock);
        while (!(ram_wren === 1'b1 && ram_wraddress === 4'd9) && n < 40) begin
            @(negedge clock);
            n++;
        end
        check("midrst_reached_9", (n < 40), 1);
        rst_n = 1'b0;
        #1;
        check("midrst_wren", ram_wren, 0);
        check("midrst_busy", busy, 1);
        @(posedge clock); #1;
        check("midrst_wren_held", ram_wren, 0);
        rst_n = 1'b1;
        sweep_check("restart");
        @(negedge clock);
        check("restart_done_busy", busy, 0);
        @(posedge clock); #1;

        // Random traffic against the reference model
        for (int k = 0; k < 16; k++) mem_m[k] = '0;
        sweep_left = 0;
        pref_fill  = 1'b1;
        last_a     = 4'd15;
        last_d     = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if (!fill_valid && $urandom_range(0, 1) == 1) begin
                fill_valid = 1'b1; fill_addr = AW'($urandom_range(0, 15)); fill_data = DW'($urandom);
            end
            if (!store_valid && $urandom_range(0, 1) == 1) begin
                store_valid = 1'b1; store_addr = AW'($urandom_range(0, 15)); store_data = DW'($urandom);
            end
            flush_req = ($urandom_range(0, 39) == 0);
            rd_addr   = AW'($urandom_range(0, 15));

            take_f = 1'b0; take_s = 1'b0;
            if (sweep_left > 0) begin
                e_busy = 1'b1; e_fr = 1'b0; e_sr = 1'b0; e_wr = 1'b1;
                e_wa = AW'(16 - sweep_left); e_wd = 8'h00;
            end else begin
                e_busy = 1'b0;
                take_f = fill_valid && (!store_valid || pref_fill);
                take_s = store_valid && !take_f;
                e_fr = take_f; e_sr = take_s; e_wr = take_f || take_s;
                e_wa = take_f ? fill_addr : (take_s ? store_addr : last_a);
                e_wd = take_f ? fill_data : (take_s ? store_data : last_d);
            end
            e_rd = (FWD && e_wr && e_wa == rd_addr) ? e_wd : mem_m[rd_addr];

            @(negedge clock);
            check("rnd_busy",  busy, e_busy);
            check("rnd_frdy",  fill_ready, e_fr);
            check("rnd_srdy",  store_ready, e_sr);
            check("rnd_wren",  ram_wren, e_wr);
            check("rnd_waddr", ram_wraddress, e_wa);
            check("rnd_wdata", ram_data, e_wd);
            check("rnd_rdata", rd_data, e_rd);

            if (e_wr) begin
                mem_m[e_wa] = e_wd; last_a = e_wa; last_d = e_wd;
            end
            if (sweep_left > 0) begin
                sweep_left--;
            end else begin
                if (take_f) pref_fill = 1'b0;
                if (take_s) pref_fill = 1'b1;
                if (flush_req) sweep_left = 16;
            end

            @(posedge clock); #1;
            if (e_fr) fill_valid = 1'b0;
            if (e_sr) store_valid = 1'b0;
        end

        flush_req = 1'b0; fill_valid = 1'b0; store_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_ram_ctrl.md
Name: cache_ram_ctrl

Overview:
- Write-port controller and arbiter for the cache's simple dual-port, asynchronous-read data RAM (one write port, one read port, single clock).
- Clears the whole array after reset and on a flush command.
- Shares the single write port between a refill requester and a store requester using round-robin.
- Passes the read port through, with optional read-after-write forwarding. Sits between the cache pipeline and the RAM instance.

Parameters:
- DATA_WIDTH, 48, RAM word width; must match the RAM instance.
- ADDR_WIDTH, 11, RAM address width; depth is 2**ADDR_WIDTH.
- CLEAR_VALUE, {DATA_WIDTH{1'b0}}, word written to every entry during a clear sweep.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush_req  in  1  one-cycle pulse; starts a clear sweep.
- busy  out  1  high while a clear sweep runs.
- fill_valid  in  1  refill write request.
- fill_ready  out  1  refill write accepted this cycle.
- fill_addr  in  ADDR_WIDTH  refill write address.
- fill_data  in  DATA_WIDTH  refill write data.
- store_valid  in  1  store write request.
- store_ready  out  1  store write accepted this cycle.
- store_addr  in  ADDR_WIDTH  store write address.
- store_data  in  DATA_WIDTH  store write data.
- rd_addr  in  ADDR_WIDTH  pipeline read address.
- rd_data  out  DATA_WIDTH  pipeline read data, combinational.
- ram_wren  out  1  to RAM wren.
- ram_wraddress  out  ADDR_WIDTH  to RAM wraddress.
- ram_data  out  DATA_WIDTH  to RAM data.
- ram_rdaddress  out  ADDR_WIDTH  to RAM rdaddress, equal to rd_addr.
- ram_q  in  DATA_WIDTH  from RAM q (asynchronous read).

Behaviour:
- Clock is `clock`. Reset is `rst_n`: asynchronous, active-low.
- While rst_n is low:
  - state = CLEAR, sweep counter = 0, last_grant = STORE.
  - ram_wren = 0, fill_ready = store_ready = 0, busy = 1.
- States:
  - CLEAR: sweep in progress.
  - RUN: normal operation.
- CLEAR:
  - Each cycle: ram_wren = 1, ram_wraddress = counter, ram_data = CLEAR_VALUE; counter increments.
  - Both readys are 0; busy = 1.
  - At counter = all-ones, that write completes and the next state is RUN with counter = 0.
  - Sweep length is exactly 2**ADDR_WIDTH cycles.
- Reset asserted mid-sweep restarts the sweep from address 0.
- flush_req while in CLEAR is ignored; sweeps are not queued.
- RUN:
  - busy = 0.
  - flush_req = 1 moves to CLEAR on the next edge. Any write granted in that same cycle still completes; the flush does not cancel it.
- RUN arbitration, combinational grant within the same cycle:
  - Only fill_valid: grant fill.
  - Only store_valid: grant store.
  - Both valid: grant the requester that is not last_grant.
  - The granted ready = 1 and the RAM write fires in the same cycle (zero-cycle acceptance).
  - ram_wraddress and ram_data are muxed from the winner.
  - last_grant updates to the winner at the clock edge.
  - The losing requester holds valid, addr and data stable until its ready is seen.
- No grant: ram_wren = 0; ram_wraddress and ram_data hold the last driven values (no toggling).
- Requesters to the same address in consecutive cycles: writes land in grant order; the later grant wins.
- Read: ram_rdaddress = rd_addr and rd_data = ram_q, combinational, zero latency.
- A write becomes visible on ram_q the cycle after ram_wren.
- Reads of an address during its sweep return either the old word or CLEAR_VALUE; the pipeline must not read while busy.

Optional Feature:
- Macro: CACHE_RAM_FWD_EN.
- Defined: when ram_wren = 1 and ram_wraddress == rd_addr in the same cycle, rd_data = ram_data (new data). Otherwise rd_data = ram_q. This applies in CLEAR and in RUN.
- Not defined: rd_data = ram_q always, so a same-cycle read of the address being written returns old data.

Decomposition:
- Package cache_ram_pkg holds:
  - state enum {CLEAR, RUN};
  - grant enum {GNT_FILL, GNT_STORE};
  - reset default for last_grant (GNT_STORE).
- One sub-module, rr_arb2: two-requester round-robin arbiter.
  - Inputs: req[1:0], last-grant register.
  - Outputs: one-hot grant and next-last-grant.
  - The arbiter is reused by the tag-RAM controller.
- Sweep counter, FSM and datapath muxes stay in cache_ram_ctrl.

Test Plan (bench uses ADDR_WIDTH=4, DATA_WIDTH=8, CLEAR_VALUE=8'h00, RAM instance attached):
- Release rst_n and check the clear sweep:
  - busy = 1 for exactly 16 cycles;
  - ram_wraddress steps 0..15 with ram_wren = 1;
  - then busy = 0 and all 16 entries read 8'h00.
- Conflicting writes:
  - Stimulus: in RUN, fill (addr 3, 8'hA5) and store (addr 7, 8'h5A) both held valid.
  - Response: cycle 1 grants fill (ready=1), cycle 2 grants store; next cycle entry 3 = A5 and entry 7 = 5A.
- Back-to-back round-robin:
  - Stimulus: both valid continuously for 6 cycles with new data each accept.
  - Response: grants alternate F,S,F,S,F,S.
- Forwarding:
  - Stimulus: store addr 5 = 8'h3C with rd_addr = 5 in the same cycle, old entry 8'h11.
  - Response: rd_data = 3C with CACHE_RAM_FWD_EN defined, 11 without; next cycle 3C either way.
- Flush in RUN:
  - Stimulus: flush_req pulse together with a granted fill to addr 2 = 8'hFF.
  - Response: the fill completes, then 16 clear cycles; entry 2 ends at 8'h00; store_valid held during the sweep sees store_ready = 0.
- Reset mid-sweep:
  - Stimulus: assert rst_n low at sweep address 9.
  - Response: ram_wren drops immediately; after release the sweep restarts at address 0 and runs 16 cycles.
